odo_trigger: RTL and testbench
==============================

ODO_TRIGGER -- requirements
Module: odo_trigger

Interface
REQ-001 SHALL have parameter POS_W, default 32, width of position input and distance arithmetic.
REQ-002 SHALL have parameter STEP_W, default 16, width of trigger step.
REQ-003 SHALL have parameter TMR_W, default 32, width of cycle timers.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_sync  in  1  one-cycle pulse, position changed this cycle.
REQ-007 SHALL have port i_sync_counter  in  POS_W  signed encoder position, valid with i_sync.
REQ-008 SHALL have port i_enable  in  1  level, arms and runs the trigger generator.
REQ-009 SHALL have port i_step  in  STEP_W  encoder counts per trigger; 0 = no triggers.
REQ-010 SHALL have port i_dir_sel  in  1  0 = triggers on increasing position, 1 = decreasing.
REQ-011 SHALL have port i_stop_tmo  in  TMR_W  idle cycles before motion is declared stopped.
REQ-012 SHALL have port i_trig_ack  in  1  acquisition consumer accepts pending trigger.
REQ-013 SHALL have port o_trig_req  out  1  trigger request, held until acknowledged.
REQ-014 SHALL have port o_trig_cnt  out  32  triggers issued since arm.
REQ-015 SHALL have port o_period  out  TMR_W  clk cycles between the last two issued triggers.
REQ-016 SHALL have port o_moving  out  1  motion present.
REQ-017 SHALL have port o_overrun  out  1  sticky, trigger due while previous still pending.

Function
REQ-018 SHALL implement FSM IDLE, ARM, RUN; IDLE while i_enable=0; IDLE->ARM on i_enable=1; ARM->RUN after one cycle; any state->IDLE the cycle after i_enable=0.
REQ-019 SHALL in ARM: dpos = i_sync_counter (negated two's complement if i_dir_sel=1), target = dpos + i_step, o_trig_cnt, o_overrun and period timer cleared, i_dir_sel latched.
REQ-020 SHALL in RUN, on a cycle with i_sync=1 and i_step!=0, fire when signed POS_W difference (dpos - target) >= 0, then target <= target + i_step (i_step sampled at fire).
REQ-021 SHALL use modulo-2^POS_W arithmetic for dpos/target so counter wrap at 0x7FFFFFFF->0x80000000 fires correctly.
REQ-022 SHALL NOT fire on reverse motion; returning forward fires only after passing the existing target (no re-trigger of covered distance).
REQ-023 SHALL assert o_trig_req the cycle after the firing i_sync cycle; latency exactly 1 clk.
REQ-024 SHALL clear o_trig_req the cycle after i_trig_ack=1; i_trig_ack with o_trig_req=0 ignored.
REQ-025 SHALL on fire with o_trig_req=1 and i_trig_ack=0: set o_overrun, keep o_trig_req, still increment o_trig_cnt and advance target.
REQ-026 SHALL on fire coincident with i_trig_ack: keep o_trig_req=1 (new request), no overrun.
REQ-027 SHALL increment o_trig_cnt (wrapping) on every fire; o_trig_cnt held in IDLE.
REQ-028 SHALL count cycles since arm/last fire in a saturating timer; on fire o_period <= timer value, timer <= 1.
REQ-029 SHALL count cycles since last i_sync in a saturating timer in all states; i_sync sets o_moving=1 and timer to 0; o_moving=0 when timer >= i_stop_tmo; i_stop_tmo=0 gives o_moving=i_sync registered.
REQ-030 SHALL on i_enable falling clear o_trig_req; i_dir_sel changes take effect only at next arm.

Reset
REQ-031 SHALL on rst_n=0 force state IDLE, o_trig_req=0, o_trig_cnt=0, o_period=0, o_moving=0, o_overrun=0, all timers 0, target 0.
REQ-032 SHALL treat rst_n deassertion mid-motion as cold start; first trigger only after ARM.

Structure
REQ-033 SHALL place state enum, POS_W/STEP_W/TMR_W defaults in shared package odo_pkg.
REQ-034 SHALL instantiate sub-module sat_cycle_counter (clear, load-1, saturate at all-ones) twice: period timer and stop timer.

Verification
REQ-035 Enable at pos 100, step 10, dir 0, 25 forward syncs -> o_trig_req at pos 110 and 120, o_trig_cnt=2.
REQ-036 Pos 110 fire, move back to 105, forward to 119 -> no new trigger; at 120 -> trigger, o_trig_cnt=2.
REQ-037 Arm at 0x7FFFFFFA, step 8, forward 10 -> single fire at 0x80000002.
REQ-038 Two fires with no ack -> o_overrun=1, o_trig_cnt=2, o_trig_req stays 1; fire coincident with ack -> o_overrun stays 0.
REQ-039 i_stop_tmo=50, syncs every 20 cycles then none -> o_moving=1, falls 50 cycles after last sync; fires 300 cycles apart -> o_period=300.
REQ-040 dir 1, arm at 0, step 5, position to -5 -> one fire; rst_n low mid-run -> all outputs 0 next edge.

Source files
------------

// File: rtl/odo_pkg.sv
// Shared definitions for the odometry trigger generator: FSM states and default widths.
package odo_pkg;

    localparam int POS_W_DEF  = 32;
    localparam int STEP_W_DEF = 16;
    localparam int TMR_W_DEF  = 32;
    localparam int TRIG_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/odo_trigger_if.sv
// Encoder-position stream in, trigger request/acknowledge handshake out.
interface odo_trigger_if import odo_pkg::*; #(
    parameter int POS_W = POS_W_DEF
) ();

    logic             i_sync;
    logic [POS_W-1:0] i_sync_counter;
    logic             i_trig_ack;
    logic             o_trig_req;

    // master = encoder source plus acquisition consumer; slave = the trigger generator
    modport master (output i_sync, i_sync_counter, i_trig_ack, input o_trig_req);
    modport slave  (input i_sync, i_sync_counter, i_trig_ack, output o_trig_req);

endinterface

// File: rtl/sat_cycle_counter.sv
// Cycle counter with synchronous clear, load-to-one and saturation at all-ones.
module sat_cycle_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load1,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // NOTE: async reset sits in the sensitivity list and all state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load1) begin
            r_cnt <= W'(1);
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/odo_trigger.sv
// Distance-based trigger generator: issues one request every i_step encoder counts of forward travel.
module odo_trigger import odo_pkg::*; #(
    parameter int POS_W  = POS_W_DEF,
    parameter int STEP_W = STEP_W_DEF,
    parameter int TMR_W  = TMR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    odo_trigger_if.slave          bus,
    input  logic                  i_enable,
    input  logic [STEP_W-1:0]     i_step,
    input  logic                  i_dir_sel,
    input  logic [TMR_W-1:0]      i_stop_tmo,
    output logic [TRIG_CNT_W-1:0] o_trig_cnt,
    output logic [TMR_W-1:0]      o_period,
    output logic                  o_moving,
    output logic                  o_overrun
);

    state_t                  r_state;
    logic [POS_W-1:0]        r_target;
    logic                    r_dir;
    logic                    r_trig_req;
    logic [TRIG_CNT_W-1:0]   r_trig_cnt;
    logic [TMR_W-1:0]        r_period;
    logic                    r_overrun;
    logic                    r_moving;

    logic [POS_W-1:0]        w_step_ext;
    logic [POS_W-1:0]        w_dpos_arm;
    logic [POS_W-1:0]        w_dpos_run;
    logic [POS_W-1:0]        w_diff;
    logic                    w_fire;
    logic [TMR_W-1:0]        w_per_cnt;
    logic [TMR_W-1:0]        w_stop_cnt;

    // Direction is folded into the position so the comparison is always "distance travelled forward".
    assign w_step_ext = POS_W'(i_step);
    assign w_dpos_arm = i_dir_sel ? -bus.i_sync_counter : bus.i_sync_counter;
    assign w_dpos_run = r_dir     ? -bus.i_sync_counter : bus.i_sync_counter;

    // Sign of the modular difference, not a signed compare of absolute values, so counter wrap is seamless.
    assign w_diff = w_dpos_run - r_target;
    assign w_fire = (r_state == RUN) && i_enable && bus.i_sync &&
                    (i_step != '0) && !w_diff[POS_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_target   <= '0;
            r_dir      <= 1'b0;
            r_trig_req <= 1'b0;
            r_trig_cnt <= '0;
            r_period   <= '0;
            r_overrun  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_trig_req <= 1'b0;
                    if (i_enable) r_state <= ARM;
                end
                ARM: begin
                    r_trig_req <= 1'b0;
                    if (!i_enable) begin
                        r_state <= IDLE;
                    end else begin
                        r_state    <= RUN;
                        r_target   <= w_dpos_arm + w_step_ext;
                        r_dir      <= i_dir_sel;
                        r_trig_cnt <= '0;
                        r_overrun  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!i_enable) begin
                        r_state    <= IDLE;
                        r_trig_req <= 1'b0;
                    end else if (w_fire) begin
                        r_target   <= r_target + w_step_ext;
                        r_trig_cnt <= r_trig_cnt + TRIG_CNT_W'(1);
                        r_period   <= w_per_cnt;
                        r_trig_req <= 1'b1;
                        if (r_trig_req && !bus.i_trig_ack) r_overrun <= 1'b1;
                    end else if (bus.i_trig_ack) begin
                        r_trig_req <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_trig_req <= 1'b0;
                end
            endcase
        end
    end

    sat_cycle_counter #(.W(TMR_W)) u_period_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (r_state == ARM),
        .i_load1 (w_fire),
        .i_inc   (r_state == RUN),
        .o_cnt   (w_per_cnt)
    );

    sat_cycle_counter #(.W(TMR_W)) u_stop_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (bus.i_sync),
        .i_load1 (1'b0),
        .i_inc   (1'b1),
        .o_cnt   (w_stop_cnt)
    );

    // Drop o_moving on the edge where the idle timer reaches i_stop_tmo; a zero timeout keeps it a one-cycle echo of i_sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_moving <= 1'b0;
        end else if (bus.i_sync) begin
            r_moving <= 1'b1;
        end else if ((i_stop_tmo == '0) || (w_stop_cnt >= i_stop_tmo - TMR_W'(1))) begin
            r_moving <= 1'b0;
        end
    end

    assign bus.o_trig_req = r_trig_req;
    assign o_trig_cnt     = r_trig_cnt;
    assign o_period       = r_period;
    assign o_moving       = r_moving;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_odo_trigger.sv
// Directed scenarios for odo_trigger; expected triggers are queued by the stimulus and matched by a monitor.
module tb_odo_trigger;
    import odo_pkg::*;

    localparam int POS_W  = 32;
    localparam int STEP_W = 16;
    localparam int TMR_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_enable;
    logic [STEP_W-1:0] i_step;
    logic              i_dir_sel;
    logic [TMR_W-1:0]  i_stop_tmo;
    logic [31:0]       o_trig_cnt;
    logic [TMR_W-1:0]  o_period;
    logic              o_moving;
    logic              o_overrun;

    always #5 clk = ~clk;

    odo_trigger_if #(.POS_W(POS_W)) bus ();

    odo_trigger #(.POS_W(POS_W), .STEP_W(STEP_W), .TMR_W(TMR_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .i_enable   (i_enable),
        .i_step     (i_step),
        .i_dir_sel  (i_dir_sel),
        .i_stop_tmo (i_stop_tmo),
        .o_trig_cnt (o_trig_cnt),
        .o_period   (o_period),
        .o_moving   (o_moving),
        .o_overrun  (o_overrun)
    );

    typedef struct {
        logic [31:0] pos;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_pos = '0;
    bit          auto_ack = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One sync pulse at pos; optional ack in the same cycle; 'gap' idle cycles afterwards.
    task automatic sync_pos(input logic [31:0] pos, input int gap, input bit fire,
                            input logic [31:0] cnt, input bit ack = 1'b0);
        exp_t e;
        @(posedge clk); #1;
        if (fire) begin
            e.pos = pos;
            e.cnt = cnt;
            exp_q.push_back(e);
        end
        bus.i_sync_counter = pos;
        bus.i_sync         = 1'b1;
        last_pos           = pos;
        if (ack) bus.i_trig_ack = 1'b1;
        @(posedge clk); #1;
        bus.i_sync = 1'b0;
        if (ack) bus.i_trig_ack = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic arm(input logic [31:0] pos, input logic [STEP_W-1:0] step, input logic dir);
        @(posedge clk); #1;
        i_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.i_sync_counter = pos;
        last_pos           = pos;
        i_step             = step;
        i_dir_sel          = dir;
        i_enable           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: every increment of o_trig_cnt is one issued trigger and must match the queue head.
    initial begin
        logic [31:0] prev;
        exp_t        e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && o_trig_cnt === prev + 32'd1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_trig: got trigger cnt=%0d at pos 0x%0h, required none", o_trig_cnt, last_pos);
                end else begin
                    e = exp_q.pop_front();
                    check("trig_cnt", 64'(o_trig_cnt), 64'(e.cnt));
                    check("trig_pos", 64'(last_pos), 64'(e.pos));
                    check("trig_req", 64'(bus.o_trig_req), 64'd1);
                end
            end
            prev = o_trig_cnt;
        end
    end

    // Consumer model: acknowledge each pending request for one cycle when auto_ack is set.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_ack) bus.i_trig_ack = bus.o_trig_req && !bus.i_trig_ack;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        i_enable           = 1'b0;
        i_step             = '0;
        i_dir_sel          = 1'b0;
        i_stop_tmo         = 32'd50;
        bus.i_sync         = 1'b0;
        bus.i_sync_counter = '0;
        bus.i_trig_ack     = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req",     64'(bus.o_trig_req), 64'd0);
        check("rst_cnt",     64'(o_trig_cnt),     64'd0);
        check("rst_period",  64'(o_period),       64'd0);
        check("rst_moving",  64'(o_moving),       64'd0);
        check("rst_overrun", 64'(o_overrun),      64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Forward run from 100, step 10: triggers at 110 and 120.
        arm(32'd100, 16'd10, 1'b0);
        for (int i = 1; i <= 25; i++)
            sync_pos(32'(100 + i), 0, (i == 10) || (i == 20), (i == 10) ? 32'd1 : 32'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("fwd_cnt", 64'(o_trig_cnt), 64'd2);

        // Back-off and return: covered distance is not re-triggered.
        arm(32'd100, 16'd10, 1'b0);
        for (int i = 101; i <= 110; i++) sync_pos(32'(i), 0, i == 110, 32'd1);
        for (int i = 109; i >= 105; i--) sync_pos(32'(i), 0, 1'b0, 32'd0);
        for (int i = 106; i <= 120; i++) sync_pos(32'(i), 0, i == 120, 32'd2);
        @(negedge clk);
        check("backoff_cnt", 64'(o_trig_cnt), 64'd2);

        // Counter wrap across 0x7FFFFFFF -> 0x80000000.
        arm(32'h7FFF_FFFA, 16'd8, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            logic [31:0] p;
            p = 32'h7FFF_FFFA + 32'(i);
            sync_pos(p, 0, p == 32'h8000_0002, 32'd1);
        end
        @(negedge clk);
        check("wrap_cnt", 64'(o_trig_cnt), 64'd1);

        // Step of zero never triggers.
        arm(32'd0, 16'd0, 1'b0);
        for (int i = 1; i <= 5; i++) sync_pos(32'(i), 0, 1'b0, 32'd0);
        @(negedge clk);
        check("step0_cnt", 64'(o_trig_cnt), 64'd0);

        // Overrun: two fires without acknowledge.
        auto_ack = 1'b0;
        arm(32'd0, 16'd5, 1'b0);
        for (int i = 1; i <= 10; i++) sync_pos(32'(i), 0, (i == 5) || (i == 10), (i == 5) ? 32'd1 : 32'd2);
        @(negedge clk);
        check("ovr_flag", 64'(o_overrun),      64'd1);
        check("ovr_cnt",  64'(o_trig_cnt),     64'd2);
        check("ovr_req",  64'(bus.o_trig_req), 64'd1);
        @(posedge clk); #1;
        bus.i_trig_ack = 1'b1;
        @(posedge clk); #1;
        bus.i_trig_ack = 1'b0;
        @(negedge clk);
        check("ack_clears_req", 64'(bus.o_trig_req), 64'd0);
        check("ovr_sticky",     64'(o_overrun),      64'd1);

        // Fire coincident with ack: request renewed, no overrun.
        arm(32'd0, 16'd5, 1'b0);
        @(negedge clk);
        check("arm_clears_ovr", 64'(o_overrun), 64'd0);
        for (int i = 1; i <= 9; i++) sync_pos(32'(i), 0, i == 5, 32'd1);
        sync_pos(32'd10, 0, 1'b1, 32'd2, 1'b1);
        @(negedge clk);
        check("coinc_req", 64'(bus.o_trig_req), 64'd1);
        check("coinc_ovr", 64'(o_overrun),      64'd0);
        @(posedge clk); #1;
        i_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("disable_clears_req", 64'(bus.o_trig_req), 64'd0);
        auto_ack = 1'b1;

        // Motion detect and period: one count every 20 cycles, step 15 -> fires 300 cycles apart.
        arm(32'd0, 16'd15, 1'b0);
        for (int i = 1; i <= 29; i++) sync_pos(32'(i), 18, i == 15, 32'd1);
        @(negedge clk);
        check("moving_between_syncs", 64'(o_moving), 64'd1);
        sync_pos(32'd30, 0, 1'b1, 32'd2);
        @(negedge clk);
        check("period_300", 64'(o_period), 64'd300);
        repeat (49) @(posedge clk);
        @(negedge clk);
        check("moving_at_49", 64'(o_moving), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("stopped_at_50", 64'(o_moving), 64'd0);

        // Reverse direction; a mid-run i_dir_sel change is ignored until re-arm.
        arm(32'd0, 16'd5, 1'b1);
        sync_pos(32'd1, 0, 1'b0, 32'd0);
        sync_pos(32'd0, 0, 1'b0, 32'd0);
        for (int i = 1; i <= 5; i++) sync_pos(32'(-i), 0, i == 5, 32'd1);
        i_dir_sel = 1'b0;
        auto_ack  = 1'b0;
        for (int i = 6; i <= 10; i++) sync_pos(32'(-i), 0, i == 10, 32'd2);
        @(negedge clk);
        check("rev_cnt", 64'(o_trig_cnt), 64'd2);

        // Asynchronous reset mid-run clears everything.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_req",     64'(bus.o_trig_req), 64'd0);
        check("midrst_cnt",     64'(o_trig_cnt),     64'd0);
        check("midrst_period",  64'(o_period),       64'd0);
        check("midrst_moving",  64'(o_moving),       64'd0);
        check("midrst_overrun", 64'(o_overrun),      64'd0);

        // Cold start with enable held: arms from the position at ARM, then triggers normally.
        i_dir_sel = 1'b1;
        auto_ack  = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sync_pos(32'(-15), 0, 1'b0, 32'd0);
        sync_pos(32'(-19), 0, 1'b0, 32'd0);
        sync_pos(32'(-20), 0, 1'b1, 32'd1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
